// File: rtl/lklist_pkg.sv
// Shared types and node-layout constants for the linked-list writer.
package lklist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    WR_TERM,
    WR_LINK
  } st_e;

  localparam int NODE_WORDS  = 2;
  localparam int NEXT_OFFSET = 1;
  localparam int NULL_PTR    = 0;

endpackage

// File: rtl/lklist_writer_ctrl.sv
// Append sequencer: drives write select and the datapath load enables.
module lklist_writer_ctrl
  import lklist_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic clear,
  input  logic full,
  input  logic first,
  output logic in_ready,
  output logic load,
  output logic clr,
  output logic done,
  output logic we,
  output logic busy,
  output st_e  sel
);

  st_e  state_q;
  logic we_q;
  logic idle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= WR_DATA;
            we_q    <= 1'b1;
          end
        end
        WR_DATA: begin
          state_q <= WR_TERM;
          we_q    <= 1'b1;
        end
        WR_TERM: begin
          if (first) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
          end else begin
            state_q <= WR_LINK;
            we_q    <= 1'b1;
          end
        end
        WR_LINK: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign idle     = (state_q == IDLE);
  assign in_ready = idle & ~full & ~clear;
  assign load     = in_ready & in_valid;
  assign clr      = idle & clear;
  // The first node has no predecessor to link, so it ends at WR_TERM.
  assign done     = ((state_q == WR_TERM) & first)
                  | (state_q == WR_LINK);
  assign busy     = ~idle;
  assign we       = we_q & rst_n;
  assign sel      = state_q;

endmodule

// File: rtl/lklist_writer.sv
// Linked-list builder: appends nodes (data, next) into a write-only RAM port.
// Optional running sum output when LKLIST_WRITER_SUM_EN is defined.
module lklist_writer
  import lklist_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              all_clk,
  input  logic              all_reset,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [ADDR_W-1:0] node_count,
  output logic              full,
  output logic              empty,
  output logic              busy
`ifdef LKLIST_WRITER_SUM_EN
  ,
  output logic [WIDTH-1:0]  list_sum
`endif
);

  localparam int NODES = 2 ** (ADDR_W - 1);

  logic [WIDTH-1:0]  cur_data_q, cur_data_d;
  logic [ADDR_W-1:0] cur_base_q, cur_base_d;
  logic [ADDR_W-1:0] alloc_base_q, alloc_base_d;
  logic [ADDR_W-1:0] prev_base_q, prev_base_d;
  logic [ADDR_W-1:0] count_q, count_d;

  logic load, clr, done, we, first;
  st_e  sel;

  assign first = (count_q == '0);
  assign full  = (count_q == ADDR_W'(NODES));
  assign empty = first;

  lklist_writer_ctrl u_ctrl (
    .clk      (all_clk),
    .rst_n    (all_reset),
    .in_valid (in_valid),
    .clear    (clear),
    .full     (full),
    .first    (first),
    .in_ready (in_ready),
    .load     (load),
    .clr      (clr),
    .done     (done),
    .we       (we),
    .busy     (busy),
    .sel      (sel)
  );

  always_comb begin
    cur_data_d   = cur_data_q;
    cur_base_d   = cur_base_q;
    alloc_base_d = alloc_base_q;
    prev_base_d  = prev_base_q;
    count_d      = count_q;
    if (load) begin
      cur_data_d = in_data;
      cur_base_d = alloc_base_q;
    end
    if (clr) begin
      count_d      = '0;
      alloc_base_d = '0;
    end
    if (done) begin
      count_d      = count_q + ADDR_W'(1);
      prev_base_d  = cur_base_q;
      alloc_base_d = alloc_base_q + ADDR_W'(NODE_WORDS);
    end
  end

  always_ff @(posedge all_clk) begin
    if (!all_reset) begin
      cur_data_q   <= '0;
      cur_base_q   <= '0;
      alloc_base_q <= '0;
      prev_base_q  <= '0;
      count_q      <= '0;
    end else begin
      cur_data_q   <= cur_data_d;
      cur_base_q   <= cur_base_d;
      alloc_base_q <= alloc_base_d;
      prev_base_q  <= prev_base_d;
      count_q      <= count_d;
    end
  end

  assign node_count = count_q;
  assign mem_we     = we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (we) begin
      unique case (1'b1)
        (sel == WR_DATA): begin
          mem_addr  = cur_base_q;
          mem_wdata = cur_data_q;
        end
        (sel == WR_TERM): begin
          mem_addr  = cur_base_q + ADDR_W'(NEXT_OFFSET);
          mem_wdata = WIDTH'(NULL_PTR);
        end
        (sel == WR_LINK): begin
          mem_addr  = prev_base_q + ADDR_W'(NEXT_OFFSET);
          mem_wdata = WIDTH'(cur_base_q);
        end
        default: begin
          mem_addr  = '0;
          mem_wdata = '0;
        end
      endcase
    end
  end

`ifdef LKLIST_WRITER_SUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) sum_d = '0;
    if (done) sum_d = sum_q + cur_data_q;
  end

  always_ff @(posedge all_clk) begin
    if (!all_reset) sum_q <= '0;
    else            sum_q <= sum_d;
  end

  assign list_sum = sum_q;
`endif

endmodule

// File: tb/tb_lklist_writer.sv
// Bench for lklist_writer: queue-based write model plus directed pins.
module tb_lklist_writer;

  localparam int W     = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NODES = 8;
  localparam int EA[8] = '{0, 1, 2, 3, 1, 4, 5, 3};
  localparam int ED[8] = '{5, 0, 7, 0, 2, 9, 0, 4};

  logic          clk = 1'b0;
  logic          all_reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          clear = 1'b0;
  logic          in_ready, mem_we, full, empty, busy;
  logic [AW-1:0] mem_addr, node_count;
  logic [W-1:0]  mem_wdata;
`ifdef LKLIST_WRITER_SUM_EN
  logic [W-1:0]  list_sum;
`endif

  always #5 clk = ~clk;

  lklist_writer #(.WIDTH(W), .ADDR_W(AW)) dut (
    .all_clk    (clk),
    .all_reset  (all_reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clear      (clear),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .node_count (node_count),
    .full       (full),
    .empty      (empty),
    .busy       (busy)
`ifdef LKLIST_WRITER_SUM_EN
    ,
    .list_sum   (list_sum)
`endif
  );

  typedef struct {
    int         a;
    logic [W-1:0] d;
  } wr_t;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  int           m_count = 0, m_alloc = 0, m_prev = 0, m_cur_base = 0;
  logic [W-1:0] m_cur_data = '0, m_sum = '0;
  wr_t          m_q[$];
  bit           m_acc;

  wr_t          log_q[$];
  logic [W-1:0] ram[DEPTH];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] walk();
    logic [W-1:0] s = '0;
    int p = 0;
    for (int i = 0; i < NODES; i++) begin
      s += ram[p];
      if (ram[(p + 1) % DEPTH] == '0) break;
      p = int'(ram[(p + 1) % DEPTH][AW-1:0]);
    end
    return s;
  endfunction

  task automatic cyc(input bit v, input logic [W-1:0] d,
                     input bit c, input bit r);
    bit bsy, rdy;
    in_valid  = v;
    in_data   = d;
    clear     = c;
    all_reset = r;
    #1;
    bsy   = (m_q.size() != 0);
    rdy   = !bsy && (m_count < NODES) && !c;
    m_acc = 0;
    if (chk_en) begin
      chk("in_ready", in_ready, rdy);
      chk("busy", busy, bsy);
      chk("node_count", node_count, m_count);
      chk("full", full, m_count == NODES);
      chk("empty", empty, m_count == 0);
      if (r && bsy) begin
        chk("mem_we", mem_we, 1);
        chk("mem_addr", mem_addr, m_q[0].a);
        chk("mem_wdata", mem_wdata, m_q[0].d);
      end else begin
        chk("mem_we_idle", mem_we, 0);
        chk("mem_addr_idle", mem_addr, 0);
        chk("mem_wdata_idle", mem_wdata, 0);
      end
`ifdef LKLIST_WRITER_SUM_EN
      chk("list_sum", list_sum, m_sum);
`endif
    end
    if (mem_we === 1'b1) begin
      log_q.push_back('{int'(mem_addr), mem_wdata});
      ram[mem_addr] = mem_wdata;
    end
    if (!r) begin
      m_count = 0;
      m_alloc = 0;
      m_prev  = 0;
      m_sum   = '0;
      m_q.delete();
    end else if (bsy) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_count++;
        m_prev  = m_cur_base;
        m_alloc = (m_alloc + 2) % DEPTH;
        m_sum   = m_sum + m_cur_data;
      end
    end else if (c) begin
      m_count = 0;
      m_alloc = 0;
      m_sum   = '0;
    end else if (v && rdy) begin
      m_acc      = 1;
      m_cur_base = m_alloc;
      m_cur_data = d;
      m_q.push_back('{m_alloc, d});
      m_q.push_back('{(m_alloc + 1) % DEPTH, '0});
      if (m_count > 0)
        m_q.push_back('{(m_prev + 1) % DEPTH, W'(m_alloc)});
    end
    @(negedge clk);
  endtask

  task automatic append(input logic [W-1:0] d);
    cyc(1, d, 0, 1);
    for (int i = 0; i < 8 && m_q.size() != 0; i++) cyc(0, '0, 0, 1);
  endtask

  task automatic do_reset();
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    log_q.delete();
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  endtask

  initial begin
    int val;
    @(negedge clk);
    cyc(0, '0, 0, 0);
    chk_en = 1;
    do_reset();

    // three appends, exact write trace
    append(5);
    append(7);
    append(9);
    chk("t1_count", node_count, 3);
    chk("t1_sum", walk(), 21);
    chk("t1_nwrites", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("t1_addr", log_q[i].a, EA[i]);
      chk("t1_data", log_q[i].d, ED[i]);
    end

    // fill to capacity with in_valid held high
    do_reset();
    val = 1;
    for (int i = 0; i < 50; i++) begin
      cyc(1, val, 0, 1);
      if (m_acc && val < 9) val++;
    end
    chk("t2_count", node_count, 8);
    chk("t2_full", full, 1);
    chk("t2_ready", in_ready, 0);
    chk("t2_sum", walk(), 36);
    chk("t2_nwrites", log_q.size(), 23);

    // clear beats in_valid
    log_q.delete();
    cyc(1, 77, 1, 1);
    chk("t3_count", node_count, 0);
    chk("t3_nowrite", log_q.size(), 0);
    append(11);
    chk("t3_addr", log_q.size() > 0 ? log_q[0].a : -1, 0);
    chk("t3_data", log_q.size() > 0 ? log_q[0].d : '1, 11);

    // reset during WR_TERM of the second node
    do_reset();
    append(3);
    cyc(1, 4, 0, 1);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 0);
    chk("t4_nwrites", log_q.size(), 3);
    in_valid  = 0;
    clear     = 0;
    all_reset = 1;
    #1;
    chk("t4_ready", in_ready, 1);
    chk("t4_count", node_count, 0);
    cyc(0, '0, 0, 1);

    // clear during WR_LINK is ignored
    log_q.delete();
    append(1);
    cyc(1, 2, 0, 1);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 1);
    chk("t5_count", node_count, 2);
    chk("t5_link_addr", log_q.size() > 0 ? log_q[log_q.size()-1].a : -1, 1);
    chk("t5_link_data", log_q.size() > 0 ? log_q[log_q.size()-1].d : '1, 2);

`ifdef LKLIST_WRITER_SUM_EN
    do_reset();
    append(32'hFFFF_FFFF);
    append(2);
    chk("sum_wrap", list_sum, 1);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom,
          $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
